// File: rtl/muldiv_issue_ctrl.sv
// EX-stage sequencer for the iterative mul_div unit: launches ops, resolves divide special cases
// locally, drains flushed ops and enforces a watchdog. Op encoding: MUL..MULHU = 0..3, DIV..REMU = 4..7.
module muldiv_issue_ctrl #(
    parameter int XLEN_WIDTH  = 32,
    parameter int TIMEOUT     = 64,
    parameter bit SHORTCUT_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    input  logic [3:0]            req_op,
    input  logic [XLEN_WIDTH-1:0] req_a,
    input  logic [XLEN_WIDTH-1:0] req_b,
    input  logic                  flush,
    output logic                  stall_o,
    output logic                  resp_valid,
    output logic [XLEN_WIDTH-1:0] resp_result,
    output logic                  md_start,
    output logic [3:0]            md_operation,
    output logic [XLEN_WIDTH-1:0] md_operand1,
    output logic [XLEN_WIDTH-1:0] md_operand2,
    input  logic [XLEN_WIDTH-1:0] md_result,
    input  logic                  md_ready,
    output logic                  err_timeout
);
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_DIVU = 4'd5;
    localparam logic [3:0] OP_REM  = 4'd6;
    localparam logic [3:0] OP_REMU = 4'd7;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [XLEN_WIDTH-1:0] INT_MIN = {1'b1, {(XLEN_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [XLEN_WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    md_start_q, md_start_d;
    logic [3:0]              md_op_q, md_op_d;
    logic [XLEN_WIDTH-1:0]   md_a_q, md_a_d;
    logic [XLEN_WIDTH-1:0]   md_b_q, md_b_d;
    logic                    err_q, err_d;

    logic is_div, is_rem, div_zero, div_ovf, ready_seen, expired;

    always_comb begin
        is_div   = (req_op == OP_DIV) || (req_op == OP_DIVU) || (req_op == OP_REM) || (req_op == OP_REMU);
        is_rem   = (req_op == OP_REM) || (req_op == OP_REMU);
        div_zero = SHORTCUT_EN && is_div && (req_b == '0);
        div_ovf  = SHORTCUT_EN && ((req_op == OP_DIV) || (req_op == OP_REM))
                   && (req_a == INT_MIN) && (req_b == '1);
        // md_ready in the start cycle belongs to whatever mul_div was doing before the launch
        ready_seen = md_ready && !md_start_q;
        expired    = (cnt_q >= CNT_W'(TIMEOUT - 1));
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        md_start_d = 1'b0;
        md_op_d    = md_op_q;
        md_a_d     = md_a_q;
        md_b_d     = md_b_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    if (div_zero) begin
                        result_d = is_rem ? req_a : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = is_rem ? '0 : INT_MIN;
                        state_d  = S_DONE;
                    end else begin
                        md_op_d    = req_op;
                        md_a_d     = req_a;
                        md_b_d     = req_b;
                        md_start_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (ready_seen) begin
                    result_d = md_result;
                    state_d  = S_DONE;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end else if (expired) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = S_DONE;
                end
            end
            S_DRAIN: begin
                // mul_div cannot abort, so the flushed op's result is swallowed here
                cnt_d = cnt_q + 1'b1;
                if (ready_seen) begin
                    state_d = S_IDLE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            result_q   <= '0;
            cnt_q      <= '0;
            md_start_q <= 1'b0;
            md_op_q    <= '0;
            md_a_q     <= '0;
            md_b_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
            md_start_q <= md_start_d;
            md_op_q    <= md_op_d;
            md_a_q     <= md_a_d;
            md_b_q     <= md_b_d;
            err_q      <= err_d;
        end
    end

    assign stall_o      = req_valid && (state_q != S_DONE) && !flush;
    assign resp_valid   = (state_q == S_DONE) && !flush;
    assign resp_result  = result_q;
    assign md_start     = md_start_q;
    assign md_operation = md_op_q;
    assign md_operand1  = md_a_q;
    assign md_operand2  = md_b_q;
    assign err_timeout  = err_q;
endmodule
